// File: rtl/dram_mem_arbiter_if.sv
// Bundle of upstream requester signals and the downstream memory port
// of the DRAM memory arbiter. The arbiter uses the slave view; whoever
// drives the requesters and models the memory uses the master view.
interface dram_mem_arbiter_if #(
    parameter int NumReq    = 2,
    parameter int AddrWidth = 48,
    parameter int DataWidth = 64
);
    logic [NumReq-1:0]                      req_i;
    logic [NumReq-1:0][AddrWidth-1:0]       addr_i;
    logic [NumReq-1:0]                      we_i;
    logic [NumReq-1:0][DataWidth-1:0]       wdata_i;
    logic [NumReq-1:0][DataWidth/8-1:0]     be_i;
    logic [NumReq-1:0]                      gnt_o;
    logic [NumReq-1:0]                      rvalid_o;
    logic [DataWidth-1:0]                   rdata_o;

    logic                                   mem_req_o;
    logic [AddrWidth-1:0]                   mem_addr_o;
    logic                                   mem_we_o;
    logic [DataWidth-1:0]                   mem_wdata_o;
    logic [DataWidth/8-1:0]                 mem_be_o;
    logic                                   mem_gnt_i;
    logic                                   mem_rvalid_i;
    logic [DataWidth-1:0]                   mem_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, be_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, be_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
    );
endinterface

// File: rtl/dram_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NumReq
// requesters. A stalled request locks the selection until it transfers;
// a small ID FIFO routes each in-order response back to its requester.
module dram_mem_arbiter #(
    parameter int NumReq         = 2,
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dram_mem_arbiter_if.slave    bus,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int IdW  = $clog2(NumReq);
    localparam int PtrW = $clog2(MaxOutstanding);
    localparam int CntW = PtrW + 1;

    logic [IdW-1:0]  rr_ptr;
    logic [IdW-1:0]  lock_id;
    logic            lock;
    logic [IdW-1:0]  sel;
    logic            sel_valid;
    logic            lock_drop;
    logic            xfer;
    logic            pop;
    logic            full;
    logic            empty;
    logic [IdW-1:0]  id_fifo [MaxOutstanding];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] cnt;
    logic [IdW-1:0]  head;

    assign full  = (cnt == CntW'(MaxOutstanding));
    assign empty = (cnt == '0);
    assign head  = id_fifo[rptr];

    // Select a requester: a live lock wins, else first request at or after rr_ptr
    always_comb begin
        logic [IdW:0] sum;
        sum       = '0;
        sel       = rr_ptr;
        sel_valid = 1'b0;
        lock_drop = lock && !bus.req_i[lock_id];
        if (lock && bus.req_i[lock_id]) begin
            sel       = lock_id;
            sel_valid = 1'b1;
        end else begin
            // Walk backwards so the closest candidate to rr_ptr is written last
            for (int i = NumReq - 1; i >= 0; i--) begin
                sum = {1'b0, rr_ptr} + (IdW + 1)'(i);
                if (sum >= (IdW + 1)'(NumReq)) begin
                    sum = sum - (IdW + 1)'(NumReq);
                end
                if (bus.req_i[sum[IdW-1:0]]) begin
                    sel       = sum[IdW-1:0];
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Full FIFO blocks requests on occupancy alone, so a same-cycle pop cannot reach mem_req_o
    assign bus.mem_req_o   = rst_ni && sel_valid && !full;
    assign bus.mem_addr_o  = bus.addr_i[sel];
    assign bus.mem_we_o    = bus.we_i[sel];
    assign bus.mem_wdata_o = bus.wdata_i[sel];
    assign bus.mem_be_o    = bus.be_i[sel];
    assign bus.rdata_o     = bus.mem_rdata_i;

    assign xfer   = bus.mem_req_o && bus.mem_gnt_i;
    assign pop    = bus.mem_rvalid_i && !empty;
    assign busy_o = !empty;

    // Grant the selected requester only in its transfer cycle
    always_comb begin
        bus.gnt_o = '0;
        if (xfer) begin
            bus.gnt_o[sel] = 1'b1;
        end
    end

    // Route a response to the requester at the FIFO head
    always_comb begin
        bus.rvalid_o = '0;
        if (pop) begin
            bus.rvalid_o[head] = 1'b1;
        end
    end

    // Round-robin pointer and stall lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
        end else begin
            if (xfer) begin
                rr_ptr <= (sel == IdW'(NumReq - 1)) ? '0 : sel + 1'b1;
            end
            if (bus.mem_req_o && !bus.mem_gnt_i) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end else if (xfer || lock_drop) begin
                lock <= 1'b0;
            end
        end
    end

    // ID FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (xfer) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({xfer, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ID FIFO storage; entries are only meaningful below the occupancy count
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            id_fifo[wptr] <= sel;
        end
    end

    // Sticky protocol error: dropped locked request or response with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (lock_drop || (bus.mem_rvalid_i && empty)) begin
            err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_mem_arbiter.sv
// Directed bench for dram_mem_arbiter: the stimulus process queues the
// expected grants and responses; a monitor pops and compares them
// whenever the arbiter presents a grant or a response.
module tb_dram_mem_arbiter;
    localparam int NR = 2;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int MO = 4;

    typedef struct {
        int              id;
        logic [AW-1:0]   addr;
        logic            we;
        logic [DW-1:0]   wdata;
    } gnt_t;

    typedef struct {
        int              id;
        logic [DW-1:0]   data;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic busy_o;
    logic err_o;

    int checks = 0;
    int errors = 0;

    gnt_t exp_gnt [$];
    rsp_t exp_rsp [$];
    gnt_t eg;
    rsp_t er;

    bit            mem_auto = 1'b0;
    logic [DW-1:0] rsp_pipe [$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    dram_mem_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW)) bus ();

    dram_mem_arbiter #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic push_gnt(input int id, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        gnt_t g;
        g.id = id; g.addr = a; g.we = we; g.wdata = wd;
        exp_gnt.push_back(g);
    endtask

    task automatic push_rsp(input int id, input logic [DW-1:0] d);
        rsp_t r;
        r.id = id; r.data = d;
        exp_rsp.push_back(r);
    endtask

    // One clock: memory model observes the transfer, then returns a latency-1 response
    task automatic step();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] t;
        @(negedge clk_i);
        if (rst_ni && bus.mem_req_o && bus.mem_gnt_i) begin
            a = bus.mem_addr_o;
            if (!mem.exists(a)) mem[a] = {16'hA5A5, a};
            if (bus.mem_we_o) begin
                t = mem[a];
                for (int b = 0; b < DW / 8; b++)
                    if (bus.mem_be_o[b]) t[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
                mem[a] = t;
                d = '0;
            end else begin
                d = mem[a];
            end
            if (mem_auto) rsp_pipe.push_back(d);
        end
        @(posedge clk_i);
        #1;
        if (mem_auto) begin
            if (rsp_pipe.size() > 0) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = rsp_pipe.pop_front();
            end else begin
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rdata_i  = '0;
            end
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (bus.gnt_o != '0) begin
            check("gnt_onehot", 64'($onehot(bus.gnt_o)), 64'd1);
            if (exp_gnt.size() == 0) begin
                check("gnt_unexpected", 64'(bus.gnt_o), 64'd0);
            end else begin
                eg = exp_gnt.pop_front();
                check("gnt_id", 64'(onehot_idx(bus.gnt_o)), 64'(eg.id));
                check("gnt_addr", 64'(bus.mem_addr_o), 64'(eg.addr));
                check("gnt_we", 64'(bus.mem_we_o), 64'(eg.we));
                if (eg.we) check("gnt_wdata", bus.mem_wdata_o, eg.wdata);
            end
        end
        if (bus.rvalid_o != '0) begin
            check("rvalid_onehot", 64'($onehot(bus.rvalid_o)), 64'd1);
            if (exp_rsp.size() == 0) begin
                check("rvalid_unexpected", 64'(bus.rvalid_o), 64'd0);
            end else begin
                er = exp_rsp.pop_front();
                check("rvalid_id", 64'(onehot_idx(bus.rvalid_o)), 64'(er.id));
                check("rdata", bus.rdata_o, er.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b1;
        bus.req_i = '1; bus.addr_i = '0; bus.we_i = '0; bus.wdata_i = '0; bus.be_i = '1;
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = '0;
        #1 rst_ni = 1'b0;

        // Reset holds everything quiet despite active inputs
        step(); step();
        #1;
        check("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
        check("rst_gnt", 64'(bus.gnt_o), 64'd0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        bus.req_i = '0; bus.mem_rvalid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();

        // Round robin with both requesters held
        mem_auto = 1'b1;
        bus.addr_i[0] = 48'h100; bus.addr_i[1] = 48'h200; bus.req_i = 2'b11;
        push_gnt(0, 48'h100, 1'b0, '0); push_gnt(1, 48'h200, 1'b0, '0);
        push_gnt(0, 48'h100, 1'b0, '0); push_gnt(1, 48'h200, 1'b0, '0);
        push_rsp(0, 64'hA5A5_0000_0000_0100); push_rsp(1, 64'hA5A5_0000_0000_0200);
        push_rsp(0, 64'hA5A5_0000_0000_0100); push_rsp(1, 64'hA5A5_0000_0000_0200);
        repeat (4) step();
        bus.req_i = '0;
        step(); step();
        #1 check("rr_idle_busy", 64'(busy_o), 64'd0);

        // Lock: move rr_ptr to 1 first so the lock is what keeps requester 0
        bus.req_i = 2'b01; bus.addr_i[0] = 48'h500;
        push_gnt(0, 48'h500, 1'b0, '0); push_rsp(0, 64'hA5A5_0000_0000_0500);
        step();
        bus.addr_i[0] = 48'h300; bus.mem_gnt_i = 1'b0;
        #1 check("lock_c0_addr", 64'(bus.mem_addr_o), 64'h300);
        check("lock_c0_req", 64'(bus.mem_req_o), 64'd1);
        step();
        bus.req_i = 2'b11; bus.addr_i[1] = 48'h400;
        #1 check("lock_c1_addr", 64'(bus.mem_addr_o), 64'h300);
        check("lock_c1_gnt", 64'(bus.gnt_o), 64'd0);
        step();
        #1 check("lock_c2_addr", 64'(bus.mem_addr_o), 64'h300);
        step();
        bus.mem_gnt_i = 1'b1;
        push_gnt(0, 48'h300, 1'b0, '0); push_rsp(0, 64'hA5A5_0000_0000_0300);
        push_gnt(1, 48'h400, 1'b0, '0); push_rsp(1, 64'hA5A5_0000_0000_0400);
        #1 check("lock_c3_addr", 64'(bus.mem_addr_o), 64'h300);
        step();
        bus.req_i = 2'b10;
        step();
        bus.req_i = '0;
        step(); step();

        // Full FIFO with no responses coming back
        mem_auto = 1'b0; bus.mem_rvalid_i = 1'b0;
        bus.addr_i[0] = 48'h600; bus.addr_i[1] = 48'h700; bus.req_i = 2'b11;
        push_gnt(0, 48'h600, 1'b0, '0); push_gnt(1, 48'h700, 1'b0, '0);
        push_gnt(0, 48'h600, 1'b0, '0); push_gnt(1, 48'h700, 1'b0, '0);
        repeat (4) step();
        #1 check("full_req", 64'(bus.mem_req_o), 64'd0);
        check("full_gnt", 64'(bus.gnt_o), 64'd0);
        check("full_busy", 64'(busy_o), 64'd1);
        step();
        #1 check("full_hold_req", 64'(bus.mem_req_o), 64'd0);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h1234;
        push_rsp(0, 64'h1234);
        #1 check("full_pop_req", 64'(bus.mem_req_o), 64'd0);
        check("full_pop_gnt", 64'(bus.gnt_o), 64'd0);
        step();
        bus.mem_rvalid_i = 1'b0;
        push_gnt(0, 48'h600, 1'b0, '0);
        #1 check("full_regrant_req", 64'(bus.mem_req_o), 64'd1);
        step();
        #1 check("full_again_req", 64'(bus.mem_req_o), 64'd0);
        bus.req_i = '0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'h5678;
        push_rsp(1, 64'h5678);
        step();
        bus.mem_rvalid_i = 1'b0;
        #1 check("full_three_busy", 64'(busy_o), 64'd1);

        // Reset with three IDs outstanding
        rst_ni = 1'b0;
        bus.addr_i[0] = 48'h800; bus.addr_i[1] = 48'h900; bus.req_i = 2'b11;
        #1 check("rstmid_busy", 64'(busy_o), 64'd0);
        check("rstmid_req", 64'(bus.mem_req_o), 64'd0);
        step();
        rst_ni = 1'b1; mem_auto = 1'b1;
        push_gnt(0, 48'h800, 1'b0, '0); push_rsp(0, 64'hA5A5_0000_0000_0800);
        push_gnt(1, 48'h900, 1'b0, '0); push_rsp(1, 64'hA5A5_0000_0000_0900);
        step();
        bus.req_i = 2'b10;
        step();
        bus.req_i = '0;
        step(); step();

        // Response with nothing outstanding since reset
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1; mem_auto = 1'b0;
        step();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 64'hBAD;
        #1 check("oor_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("oor_err_before", 64'(err_o), 64'd0);
        step();
        bus.mem_rvalid_i = 1'b0;
        #1 check("oor_err_set", 64'(err_o), 64'd1);
        step(); step();
        #1 check("oor_err_sticky", 64'(err_o), 64'd1);

        // Write then read back the same address from the other requester
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1 check("err_cleared", 64'(err_o), 64'd0);
        mem_auto = 1'b1;
        bus.req_i = 2'b10; bus.we_i = 2'b10; bus.addr_i[1] = 48'h80;
        bus.wdata_i[1] = 64'hCAFE_BABE_1234_5678; bus.be_i = '1;
        push_gnt(1, 48'h80, 1'b1, 64'hCAFE_BABE_1234_5678); push_rsp(1, 64'h0);
        step();
        bus.req_i = 2'b01; bus.we_i = '0; bus.addr_i[0] = 48'h80;
        push_gnt(0, 48'h80, 1'b0, '0); push_rsp(0, 64'hCAFE_BABE_1234_5678);
        step();
        bus.req_i = '0;
        step(); step(); step();

        check("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dram_mem_arbiter.md
DRAM_MEM_ARBITER -- requirements
Module: dram_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NumReq, 2, number of upstream memory requesters; legal range 2..8.
- AddrWidth, 48, byte address width.
- DataWidth, 64, data width; a multiple of 8.
- MaxOutstanding, 4, depth of the response-routing FIFO; a power of two, at least 2.

REQ-002 Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low.

REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_i, in, NumReq, per-requester request.
- addr_i, in, NumReq x AddrWidth, per-requester address.
- we_i, in, NumReq, per-requester write enable.
- wdata_i, in, NumReq x DataWidth, per-requester write data.
- be_i, in, NumReq x DataWidth/8, per-requester byte enables.
- gnt_o, out, NumReq, per-requester grant.
- rvalid_o, out, NumReq, per-requester response valid.
- rdata_o, out, DataWidth, response data, shared by all requesters.
- mem_req_o, out, 1, downstream request.
- mem_addr_o, out, AddrWidth, downstream address.
- mem_we_o, out, 1, downstream write enable.
- mem_wdata_o, out, DataWidth, downstream write data.
- mem_be_o, out, DataWidth/8, downstream byte enables.
- mem_gnt_i, in, 1, downstream grant.
- mem_rvalid_i, in, 1, downstream response valid; one response per accepted request, reads and writes alike, in order.
- mem_rdata_i, in, DataWidth, downstream response data.
- busy_o, out, 1, high when at least one request is outstanding.
- err_o, out, 1, sticky protocol error flag.

Function
REQ-004 Handshake: a transfer occurs in a cycle with mem_req_o && mem_gnt_i; gnt_o[s] SHALL be asserted in exactly that cycle, where s is the selected requester.
REQ-005 Downstream outputs SHALL be driven combinationally from the inputs of the selected requester; no added request latency.
REQ-006 Arbitration SHALL be round-robin: search starts at rr_ptr and wraps modulo NumReq; the first requester with req_i high is selected.
REQ-007 rr_ptr SHALL advance to (s+1) mod NumReq only on a transfer; otherwise it holds.
REQ-008 Lock: if mem_req_o is high and mem_gnt_i is low, the arbiter SHALL lock selection on s.
- The next cycle keeps the same s regardless of other requests.
- The lock is released on that requester's transfer.
REQ-009 Requesters SHALL hold req_i and payload stable until granted. If a locked requester drops req_i, err_o SHALL set and the lock SHALL release.
REQ-010 Routing FIFO: every transfer SHALL push s into an ID FIFO of depth MaxOutstanding.
REQ-011 Each mem_rvalid_i SHALL pop the FIFO head h and drive rvalid_o[h] = 1 in the same cycle; rdata_o = mem_rdata_i, a combinational pass-through.
REQ-012 Full FIFO: mem_req_o SHALL be 0 and all gnt_o bits 0, even if a pop occurs in the same cycle; there is no combinational path from mem_rvalid_i to mem_req_o.
REQ-013 Simultaneous push and pop when not full SHALL both take effect; occupancy is unchanged.
REQ-014 mem_rvalid_i with an empty FIFO SHALL set err_o, and all rvalid_o bits SHALL stay 0.
REQ-015 busy_o SHALL equal (FIFO occupancy != 0).
REQ-016 Occupancy counter width SHALL be $clog2(MaxOutstanding)+1; read/write pointers wrap modulo MaxOutstanding.
REQ-017 Unselected requesters SHALL see gnt_o = 0. rvalid_o SHALL be one-hot or zero.

Reset
REQ-018 While rst_ni is low the block SHALL hold:
- rr_ptr = 0, lock cleared, FIFO empty, err_o = 0.
- mem_req_o = 0, gnt_o = 0, rvalid_o = 0, busy_o = 0.
REQ-019 Reset asserted mid-operation SHALL discard outstanding IDs. Responses arriving after reset release are errors per REQ-014.
REQ-020 err_o SHALL clear only on reset.

Verification
REQ-021 The bench SHALL cover the following directed scenarios.
- Round robin: NumReq=2; req_i=2'b11 held, mem_gnt_i=1 -> grant order 0,1,0,1; rvalid_o order identical one cycle later with a latency-1 memory model.
- Lock: req 0 pending with mem_gnt_i=0 for 3 cycles, req 1 raised in cycle 1 -> mem_addr_o stays addr_i[0] until the grant; req 1 is granted in the following cycle.
- Full: MaxOutstanding=4, mem_rvalid_i held 0, 6 requests -> exactly 4 grants, then mem_req_o=0 and busy_o=1; one mem_rvalid_i -> exactly one more grant, the cycle after.
- Out-of-range response: mem_rvalid_i=1 with no transfer since reset -> err_o=1 the next cycle and stays 1; rvalid_o=0.
- Reset mid-flight: 3 outstanding, rst_ni pulsed low -> busy_o=0 immediately; after release, the first grant goes to requester 0.
- Mixed reads and writes: write to 0x80 from req 1, then read of 0x80 from req 0 -> rvalid_o[1] then rvalid_o[0] with rdata_o = the written data.
